hazard_scoreboard_unit: RTL and testbench
=========================================

HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 SHALL have parameter RAW, default 5: register-address width; 4 selects RV32E.
REQ-002 SHALL have parameter MC_LAT, default 4: multi-cycle (mul/div) EXE occupancy in cycles; legal range 2..16.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have inputs rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE  in  RAW each  register addresses.
REQ-006 SHALL have inputs rs1use_ID, rs2use_ID, Branch_ID, RegWrite_EXE, RegWrite_MEM, DatatoReg_EXE, DatatoReg_MEM, mem_w_EXE  in  1 each  decode/pipeline qualifiers.
REQ-007 SHALL have inputs mc_start_EXE  in  1  (multi-cycle op entering EXE); mem_req_MEM  in  1; mem_ready  in  1  (data memory handshake).
REQ-008 SHALL have outputs PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush  out  1 each.
REQ-009 SHALL have outputs forward_ctrl_A, forward_ctrl_B  out  2; forward_ctrl_ls  out  1; mc_busy  out  1.
REQ-010 SHALL have output stall_cnt  out  32  stall-cycle counter (present only per REQ-027).

Function
REQ-011 Forward A/B: 00 none; 01 rd_EXE match, RegWrite_EXE; 10 rd_MEM match, RegWrite_MEM, !DatatoReg_MEM; 11 rd_MEM match, RegWrite_MEM, DatatoReg_MEM; EXE beats MEM; requires rsXuse_ID and rsX_ID!=0.
REQ-012 forward_ctrl_ls SHALL be 1 iff mem_w_EXE, rs2_EXE==rd_MEM, rd_MEM!=0, RegWrite_MEM, DatatoReg_MEM.
REQ-013 FSM states SHALL be IDLE, MC_BUSY, MEM_WAIT; state and counter mc_cnt ($clog2(MC_LAT) bits) are registered.
REQ-014 IDLE->MC_BUSY on mc_start_EXE with mem wait absent; mc_cnt loaded MC_LAT-2.
REQ-015 MC_BUSY: mc_cnt decrements each cycle; at mc_cnt==0 returns to IDLE next edge; total EXE occupancy exactly MC_LAT cycles.
REQ-016 Any state -> MEM_WAIT when mem_req_MEM && !mem_ready; MEM_WAIT exits when mem_ready=1 to the saved state (IDLE or MC_BUSY) with mc_cnt frozen throughout.
REQ-017 MEM_WAIT outputs: PC_EN_IF, FD/DE/EM_EN = 0, MW_EN=1, MW_flush=1, other flushes 0.
REQ-018 MC_BUSY outputs: PC_EN_IF, FD_EN, DE_EN = 0; EM_EN=1 with EM_flush=1; MW_EN=1; mc_busy=1.
REQ-019 IDLE load-use (rsX match rd_EXE, RegWrite_EXE, DatatoReg_EXE, rsX used, nonzero): PC_EN_IF=0, FD_EN=0, DE_flush=1, one cycle.
REQ-020 IDLE Branch_ID without load-use: FD_flush=1, PC_EN_IF=1.
REQ-021 Priority SHALL be mem wait > MC_BUSY > load-use > branch > normal (all EN=1, flushes 0).
REQ-022 mc_start_EXE asserted while not IDLE SHALL be ignored.
REQ-023 Forwarding outputs SHALL stay combinational and valid in every state.

Reset
REQ-024 rst_n low SHALL force state IDLE and mc_cnt 0 immediately, regardless of clk.
REQ-025 While rst_n low: all EN outputs 0, all flushes 0, forward outputs 0, mc_busy 0, stall_cnt 0.
REQ-026 Reset mid MC_BUSY or MEM_WAIT SHALL abandon the operation; first cycle after release is IDLE normal.

Configuration
REQ-027 Macro HAZARD_STALL_CNT_EN: defined -> stall_cnt increments each cycle PC_EN_IF=0 (rst_n high), saturates at 32'hFFFF_FFFF; undefined -> port absent, no counter logic.

Verification
REQ-028 rd_EXE=5, RegWrite_EXE=1, rs1_ID=5 used, DatatoReg_EXE=0 -> forward_ctrl_A=01, no stall.
REQ-029 Load rd_EXE=7, rs2_ID=7 used -> 1 cycle PC_EN_IF=0, DE_flush=1; next cycle rd_MEM=7 -> forward_ctrl_B=11.
REQ-030 MC_LAT=4, mc_start_EXE pulse -> mc_busy=1 exactly 4 cycles, EM_flush=1 those cycles, then IDLE.
REQ-031 MC_BUSY cycle 2, mem_ready=0 for 3 cycles -> MEM_WAIT 3 cycles, then MC_BUSY resumes for remaining 2 cycles.
REQ-032 rst_n low during MC_BUSY mid-cycle -> outputs reset without clock edge; stall_cnt=0; after release, normal enables.
REQ-033 HAZARD_STALL_CNT_EN defined, 10 stall cycles from reset -> stall_cnt=10.

Source files
------------

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Pipeline hazard controller for a five-stage in-order core. It produces
//   operand forwarding selects, load-use stalls, branch flushes, multi-cycle
//   (mul/div) EXE occupancy and data-memory wait freezes.
//
// Parameters
//   RAW     register-address width (4 = RV32E, 5 = RV32I)
//   MC_LAT  EXE occupancy of a multi-cycle op, in cycles (2..16)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rs1_ID, rs2_ID, rs1use_ID, rs2use_ID, Branch_ID     decode-stage info
//   rd_EXE, RegWrite_EXE, DatatoReg_EXE, mem_w_EXE, rs2_EXE, mc_start_EXE
//   rd_MEM, RegWrite_MEM, DatatoReg_MEM, mem_req_MEM    memory-stage info
//   mem_ready                  data memory ready
//   PC_EN_IF, reg_*_EN, reg_*_flush   pipeline register enables / flushes
//   forward_ctrl_A/B           00 none, 01 EXE, 10 MEM alu, 11 MEM load
//   forward_ctrl_ls            store data in EXE takes load result from MEM
//   mc_busy                    multi-cycle op occupying EXE
//   stall_cnt                  cycles with PC_EN_IF low (only when the
//                              HAZARD_STALL_CNT_EN macro is defined)
//
// Handshake: mem_req_MEM/mem_ready form a request/ready pair. A request with
// mem_ready low freezes the pipeline; once frozen, the freeze lasts until
// mem_ready rises, regardless of mem_req_MEM.
//
// The FSM state is held in state_q (IDLE, MC_BUSY, MEM_WAIT) for checkers.
module hazard_scoreboard_unit #(
  parameter int RAW    = 5,
  parameter int MC_LAT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [RAW-1:0] rs1_ID,
  input  logic [RAW-1:0] rs2_ID,
  input  logic [RAW-1:0] rd_EXE,
  input  logic [RAW-1:0] rd_MEM,
  input  logic [RAW-1:0] rs2_EXE,
  input  logic           rs1use_ID,
  input  logic           rs2use_ID,
  input  logic           Branch_ID,
  input  logic           RegWrite_EXE,
  input  logic           RegWrite_MEM,
  input  logic           DatatoReg_EXE,
  input  logic           DatatoReg_MEM,
  input  logic           mem_w_EXE,
  input  logic           mc_start_EXE,
  input  logic           mem_req_MEM,
  input  logic           mem_ready,
  output logic           PC_EN_IF,
  output logic           reg_FD_EN,
  output logic           reg_FD_flush,
  output logic           reg_DE_EN,
  output logic           reg_DE_flush,
  output logic           reg_EM_EN,
  output logic           reg_EM_flush,
  output logic           reg_MW_EN,
  output logic           reg_MW_flush,
  output logic [1:0]     forward_ctrl_A,
  output logic [1:0]     forward_ctrl_B,
  output logic           forward_ctrl_ls,
  output logic           mc_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cnt
`endif
);

  localparam int CW = $clog2(MC_LAT);
  // The start cycle (seen in IDLE) is the first occupancy cycle, so the
  // counter covers the remaining MC_LAT-1 cycles: MC_LAT-2 down to 0.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

  typedef enum logic [1:0] {IDLE, MC_BUSY, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          saved_busy_q, saved_busy_d;

  logic eff_busy;
  logic mem_stall;
  logic mc_accept;
  logic load_use;

  function automatic logic [1:0] fwd_sel(input logic use_, input logic [RAW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_ && rs != '0) begin
      if (RegWrite_EXE && rd_EXE == rs)      sel = 2'b01;
      else if (RegWrite_MEM && rd_MEM == rs) sel = DatatoReg_MEM ? 2'b11 : 2'b10;
    end
    return sel;
  endfunction

  // Forwarding is independent of the FSM and valid in every state.
  assign forward_ctrl_A  = rst_n ? fwd_sel(rs1use_ID, rs1_ID) : 2'b00;
  assign forward_ctrl_B  = rst_n ? fwd_sel(rs2use_ID, rs2_ID) : 2'b00;
  assign forward_ctrl_ls = rst_n & mem_w_EXE & (rs2_EXE == rd_MEM) & (rd_MEM != '0)
                           & RegWrite_MEM & DatatoReg_MEM;

  // While frozen in MEM_WAIT the FSM behaves as the state it left once the
  // memory becomes ready, so the exit cycle is a normal cycle of that state.
  assign eff_busy  = (state_q == MC_BUSY) || (state_q == MEM_WAIT && saved_busy_q);
  assign mem_stall = (state_q == MEM_WAIT) ? !mem_ready : (mem_req_MEM && !mem_ready);
  assign mc_accept = (state_q == IDLE) && mc_start_EXE && !mem_stall;
  assign load_use  = RegWrite_EXE && DatatoReg_EXE &&
                     ((rs1use_ID && rs1_ID != '0 && rs1_ID == rd_EXE) ||
                      (rs2use_ID && rs2_ID != '0 && rs2_ID == rd_EXE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      saved_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      saved_busy_q <= saved_busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    saved_busy_d = saved_busy_q;
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_EN    = 1'b1;
    reg_DE_flush = 1'b0;
    reg_EM_EN    = 1'b1;
    reg_EM_flush = 1'b0;
    reg_MW_EN    = 1'b1;
    reg_MW_flush = 1'b0;
    mc_busy      = 1'b0;

    if (mem_stall) begin
      // Freeze everything up to MEM; mc_cnt holds its value.
      state_d      = MEM_WAIT;
      saved_busy_d = eff_busy;
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_EM_EN    = 1'b0;
      reg_MW_flush = 1'b1;
    end else if (eff_busy || mc_accept) begin
      // EXE held by the multi-cycle op: bubble into MEM behind it.
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_EM_flush = 1'b1;
      mc_busy      = 1'b1;
      if (mc_accept) begin
        state_d = MC_BUSY;
        cnt_d   = CNT_LOAD;
      end else if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        state_d = MC_BUSY;
        cnt_d   = cnt_q - CW'(1);
      end
    end else begin
      state_d = IDLE;
      if (load_use) begin
        PC_EN_IF     = 1'b0;
        reg_FD_EN    = 1'b0;
        reg_DE_flush = 1'b1;
      end else if (Branch_ID) begin
        reg_FD_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_FD_flush = 1'b0;
      reg_DE_EN    = 1'b0;
      reg_DE_flush = 1'b0;
      reg_EM_EN    = 1'b0;
      reg_EM_flush = 1'b0;
      reg_MW_EN    = 1'b0;
      reg_MW_flush = 1'b0;
      mc_busy      = 1'b0;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!PC_EN_IF && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit: directed scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model that
// tracks "busy cycles remaining" and "frozen on memory" as plain variables.
module tb_hazard_scoreboard_unit;
  localparam int RAW    = 5;
  localparam int MC_LAT = 4;

  // Expected control words, packed as
  // {PC_EN_IF, FD_EN, FD_flush, DE_EN, DE_flush, EM_EN, EM_flush, MW_EN, MW_flush, mc_busy}
  localparam logic [9:0] C_RESET  = 10'b0000000000;
  localparam logic [9:0] C_WAIT   = 10'b0000000110;
  localparam logic [9:0] C_BUSY   = 10'b0000011101;
  localparam logic [9:0] C_LDUSE  = 10'b0001110100;
  localparam logic [9:0] C_BRANCH = 10'b1111010100;
  localparam logic [9:0] C_NORMAL = 10'b1101010100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [RAW-1:0] rs1_ID, rs2_ID, rd_EXE, rd_MEM, rs2_EXE;
  logic rs1use_ID, rs2use_ID, Branch_ID, RegWrite_EXE, RegWrite_MEM;
  logic DatatoReg_EXE, DatatoReg_MEM, mem_w_EXE, mc_start_EXE, mem_req_MEM, mem_ready;
  logic PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush;
  logic reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic forward_ctrl_ls, mc_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard_unit #(.RAW(RAW), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EXE(rd_EXE), .rd_MEM(rd_MEM), .rs2_EXE(rs2_EXE),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID), .Branch_ID(Branch_ID),
    .RegWrite_EXE(RegWrite_EXE), .RegWrite_MEM(RegWrite_MEM),
    .DatatoReg_EXE(DatatoReg_EXE), .DatatoReg_MEM(DatatoReg_MEM), .mem_w_EXE(mem_w_EXE),
    .mc_start_EXE(mc_start_EXE), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
    .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush), .reg_EM_EN(reg_EM_EN),
    .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN), .reg_MW_flush(reg_MW_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls), .mc_busy(mc_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- reference model ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          m_busy_rem;   // busy cycles still owed after the start cycle
  bit          m_frozen;     // pipeline frozen on a memory wait
  logic [31:0] m_stall;      // cycles with PC_EN_IF low

  task automatic m_reset();
    m_busy_rem = 0;
    m_frozen   = 1'b0;
    m_stall    = 32'd0;
  endtask

  function automatic logic m_mem_stall();
    return m_frozen ? !mem_ready : (mem_req_MEM && !mem_ready);
  endfunction

  function automatic logic [1:0] m_fwd(input logic use_, input logic [RAW-1:0] rs);
    if (!rst_n || !use_ || rs == 0) return 2'b00;
    if (RegWrite_EXE && rd_EXE == rs) return 2'b01;
    if (RegWrite_MEM && rd_MEM == rs) return DatatoReg_MEM ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [9:0] m_ctl();
    logic lu;
    if (!rst_n) return C_RESET;
    if (m_mem_stall()) return C_WAIT;
    if (m_busy_rem > 0 || (!m_frozen && mc_start_EXE)) return C_BUSY;
    lu = RegWrite_EXE && DatatoReg_EXE &&
         ((rs1use_ID && rs1_ID != 0 && rs1_ID == rd_EXE) ||
          (rs2use_ID && rs2_ID != 0 && rs2_ID == rd_EXE));
    if (lu) return C_LDUSE;
    if (Branch_ID) return C_BRANCH;
    return C_NORMAL;
  endfunction

  function automatic logic m_ls();
    return rst_n && mem_w_EXE && rs2_EXE == rd_MEM && rd_MEM != 0 && RegWrite_MEM && DatatoReg_MEM;
  endfunction

  // Advance the model over one rising edge using the current inputs.
  task automatic m_step();
    logic [9:0] e;
    if (!rst_n) begin
      m_reset();
      return;
    end
    e = m_ctl();
    if (!e[9] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    if (m_mem_stall()) begin
      m_frozen = 1'b1;
    end else begin
      if (m_busy_rem > 0) m_busy_rem = m_busy_rem - 1;
      else if (!m_frozen && mc_start_EXE) m_busy_rem = MC_LAT - 1;
      m_frozen = 1'b0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "/ctl"},
          {22'd0, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush,
           reg_EM_EN, reg_EM_flush, reg_MW_EN, reg_MW_flush, mc_busy},
          {22'd0, m_ctl()});
    check({tag, "/fwd"}, {27'd0, forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls},
          {27'd0, m_fwd(rs1use_ID, rs1_ID), m_fwd(rs2use_ID, rs2_ID), m_ls()});
`ifdef HAZARD_STALL_CNT_EN
    check({tag, "/stall_cnt"}, stall_cnt, m_stall);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    rs1_ID = '0; rs2_ID = '0; rd_EXE = '0; rd_MEM = '0; rs2_EXE = '0;
    rs1use_ID = 0; rs2use_ID = 0; Branch_ID = 0; RegWrite_EXE = 0; RegWrite_MEM = 0;
    DatatoReg_EXE = 0; DatatoReg_MEM = 0; mem_w_EXE = 0; mc_start_EXE = 0;
    mem_req_MEM = 0; mem_ready = 1;
  endtask

  // Check at the falling edge, step the model, then move inputs 1ns past the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    set_idle();
    cycle("reset");
    cycle("reset");
    rst_n = 1'b1;
  endtask

  int busy_seen, emf_seen, wait_seen;

  initial begin
    rst_n = 1'b0;
    set_idle();
    m_reset();
    #1;
    do_reset();

    // EXE ALU forward, no stall
    rd_EXE = 5; RegWrite_EXE = 1; rs1_ID = 5; rs1use_ID = 1;
    cycle("fwd_exe");
    check("fwd_exe_A", {30'd0, forward_ctrl_A}, 32'd1);

    // load-use stall, then MEM load forward
    set_idle();
    rd_EXE = 7; RegWrite_EXE = 1; DatatoReg_EXE = 1; rs2_ID = 7; rs2use_ID = 1;
    cycle("load_use");
    RegWrite_EXE = 0; DatatoReg_EXE = 0; rd_EXE = 0;
    rd_MEM = 7; RegWrite_MEM = 1; DatatoReg_MEM = 1;
    #1;
    check("ld_fwd_B", {30'd0, forward_ctrl_B}, 32'd3);
    cycle("load_fwd");

    // MEM ALU forward, store-data forward, branch flush, x0 never forwards
    set_idle();
    rd_MEM = 3; RegWrite_MEM = 1; rs1_ID = 3; rs1use_ID = 1; Branch_ID = 1;
    cycle("mem_alu_branch");
    DatatoReg_MEM = 1; mem_w_EXE = 1; rs2_EXE = 3; Branch_ID = 0;
    cycle("store_fwd");
    rd_MEM = 0; rs2_EXE = 0; rs1_ID = 0; rd_EXE = 0; RegWrite_EXE = 1;
    cycle("x0");

    // multi-cycle op occupies EXE for MC_LAT cycles
    set_idle();
    busy_seen = 0; emf_seen = 0;
    mc_start_EXE = 1;
    for (int i = 0; i < MC_LAT + 2; i++) begin
      #1;
      busy_seen += int'(mc_busy);
      emf_seen  += int'(reg_EM_flush);
      cycle("mc_run");
      mc_start_EXE = (i == 1);  // a second start while busy is ignored
    end
    check("mc_busy_cycles", busy_seen, MC_LAT);
    check("mc_em_flush_cycles", emf_seen, MC_LAT);

    // memory wait in the second busy cycle, three cycles long
    set_idle();
    busy_seen = 0; wait_seen = 0;
    for (int i = 0; i < 9; i++) begin
      mc_start_EXE = (i == 0);
      mem_req_MEM  = (i >= 2 && i <= 4);
      mem_ready    = !(i >= 2 && i <= 4);
      #1;
      busy_seen += int'(mc_busy);
      wait_seen += int'(reg_MW_flush);
      cycle("mc_wait");
    end
    check("mc_wait_busy_cycles", busy_seen, MC_LAT);
    check("mc_wait_wait_cycles", wait_seen, 3);

    // asynchronous reset in the middle of a busy op
    set_idle();
    mc_start_EXE = 1;
    cycle("pre_async");
    mc_start_EXE = 0;
    cycle("pre_async");
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_outputs("async_rst");
    cycle("in_rst");
    #2;
    rst_n = 1'b1;
    cycle("post_rst");
    check("post_rst_pc_en", {31'd0, PC_EN_IF}, 32'd1);

`ifdef HAZARD_STALL_CNT_EN
    do_reset();
    mem_req_MEM = 1; mem_ready = 0;
    for (int i = 0; i < 10; i++) cycle("stall10");
    check("stall_cnt_10", stall_cnt, 32'd10);
    set_idle();
    cycle("stall10_exit");
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rs1_ID = RAW'($urandom_range(0, 3)); rs2_ID = RAW'($urandom_range(0, 3));
      rd_EXE = RAW'($urandom_range(0, 3)); rd_MEM = RAW'($urandom_range(0, 3));
      rs2_EXE = RAW'($urandom_range(0, 3));
      rs1use_ID = 1'($urandom_range(0, 1)); rs2use_ID = 1'($urandom_range(0, 1));
      Branch_ID = ($urandom_range(0, 3) == 0);
      RegWrite_EXE = 1'($urandom_range(0, 1)); RegWrite_MEM = 1'($urandom_range(0, 1));
      DatatoReg_EXE = 1'($urandom_range(0, 1)); DatatoReg_MEM = 1'($urandom_range(0, 1));
      mem_w_EXE = 1'($urandom_range(0, 1));
      mc_start_EXE = ($urandom_range(0, 7) == 0);
      mem_req_MEM = ($urandom_range(0, 4) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      cycle("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
